// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_resp latency-modelled data memory.
// Optional build macro DMEM_ADDR_CHECK_EN affects dmem_resp only.
package dmem_pkg;

   localparam int XLEN   = 64;
   localparam int STRB_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Expands one enable bit per byte lane into a full-width bit mask.
   function automatic logic [XLEN-1:0] strbMask(input logic [STRB_W-1:0] strb);
      logic [XLEN-1:0] mask;
      mask = '0;
      for (int i = 0; i < STRB_W; i++) begin
         mask[i*8 +: 8] = {8{strb[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Request/response bus between a load-store requester (master) and dmem_resp (slave).
interface dmem_resp_if;
   import dmem_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [XLEN-1:0]   req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic [STRB_W-1:0] req_wstrb;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [XLEN-1:0]   rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// Word storage for dmem_resp: synchronous byte-strobed write, combinational read.
// Contents are deliberately not reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter  int DEPTH = 256,
   localparam int IDXW  = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [IDXW-1:0]   idx_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic [STRB_W-1:0] wstrb_i,
   output logic [XLEN-1:0]   rdata_o
);

   logic [XLEN-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wstrb_i[i]) begin
               mem_q[idx_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder with a fixed LAT-cycle response latency and a held response.
// Define DMEM_ADDR_CHECK_EN to flag out-of-range word addresses instead of wrapping them.
module dmem_resp
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int LAT   = 2
) (
   input logic        clk,
   input logic        rst_n,
   dmem_resp_if.slave bus
);

   localparam int IDXW = $clog2(DEPTH);

   state_t            state_q;
   logic [3:0]        count_q;
   logic              reqReady_q;
   logic              rspValid_q;
   logic              rspErr_q;
   logic [XLEN-1:0]   rspRdata_q;
   logic              we_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [STRB_W-1:0] wstrb_q;

   logic              inIdle;
   logic              commit;
   logic              curWe;
   logic [XLEN-1:0]   curAddr;
   logic [XLEN-1:0]   curWdata;
   logic [STRB_W-1:0] curWstrb;
   logic [IDXW-1:0]   curIdx;
   logic              inRange;
   logic [XLEN-1:0]   laneMask;
   logic [XLEN-1:0]   arrRdata;
   logic              arrWe;
   logic [XLEN-1:0]   rspRdata_d;
   logic              rspErr_d;
   logic              unused_addr;

   // With LAT=1 the commit happens on the accepting edge, so the live bus fields are used.
   assign inIdle   = (state_q == IDLE);
   assign commit   = (inIdle && bus.req_valid && (LAT == 1)) ||
                     ((state_q == WAIT) && (count_q <= 4'd1));
   assign curWe    = inIdle ? bus.req_we    : we_q;
   assign curAddr  = inIdle ? bus.req_addr  : addr_q;
   assign curWdata = inIdle ? bus.req_wdata : wdata_q;
   assign curWstrb = inIdle ? bus.req_wstrb : wstrb_q;
   assign curIdx   = curAddr[3 +: IDXW];
   assign laneMask = strbMask(curWstrb);

`ifdef DMEM_ADDR_CHECK_EN
   assign inRange  = (curAddr[XLEN-1:3] < (XLEN-3)'(DEPTH));
   assign rspErr_d = ~inRange;
`else
   assign inRange  = 1'b1;
   assign rspErr_d = 1'b0;
`endif

   assign unused_addr = ^{curAddr[2:0], curAddr[XLEN-1:3+IDXW]};
   assign arrWe       = commit && curWe && inRange;

   // The response word reflects the store being committed on the same edge.
   always_comb begin
      rspRdata_d = '0;
      if (inRange) begin
         if (curWe) begin
            rspRdata_d = (arrRdata & ~laneMask) | (curWdata & laneMask);
         end else begin
            rspRdata_d = arrRdata;
         end
      end
   end

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk_i   (clk),
      .we_i    (arrWe),
      .idx_i   (curIdx),
      .wdata_i (curWdata),
      .wstrb_i (curWstrb),
      .rdata_o (arrRdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         count_q    <= 4'd0;
         reqReady_q <= 1'b1;
         rspValid_q <= 1'b0;
         rspErr_q   <= 1'b0;
         rspRdata_q <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q       <= bus.req_we;
                  addr_q     <= bus.req_addr;
                  wdata_q    <= bus.req_wdata;
                  wstrb_q    <= bus.req_wstrb;
                  count_q    <= 4'(LAT - 1);
                  reqReady_q <= 1'b0;
                  if (LAT == 1) begin
                     state_q    <= RESP;
                     rspValid_q <= 1'b1;
                     rspRdata_q <= rspRdata_d;
                     rspErr_q   <= rspErr_d;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (count_q <= 4'd1) begin
                  count_q    <= 4'd0;
                  state_q    <= RESP;
                  rspValid_q <= 1'b1;
                  rspRdata_q <= rspRdata_d;
                  rspErr_q   <= rspErr_d;
               end else begin
                  count_q <= count_q - 4'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state_q    <= IDLE;
                  rspValid_q <= 1'b0;
                  reqReady_q <= 1'b1;
               end
            end
            default: begin
               state_q    <= IDLE;
               count_q    <= 4'd0;
               rspValid_q <= 1'b0;
               reqReady_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready = reqReady_q;
   assign bus.rsp_valid = rspValid_q;
   assign bus.rsp_rdata = rspRdata_q;
   assign bus.rsp_err   = rspErr_q;

endmodule
